// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and retry supervisor
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 100,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 7,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_ready,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic       fail
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic                   cnt_clr;
    logic [3:0]             retry_next;
    logic                   lost_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;

    // pll_lock is asynchronous; only the last synchronizer stage is trusted
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync[SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        retry_next = retry_cnt;
        lost_next  = 1'b0;
        if (restart) begin
            state_next = S_RESET;
            cnt_clr    = 1'b1;
            retry_next = 4'd0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == CW'(RST_PULSE_CYC - 1)) begin
                        state_next = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = S_STABLE;
                    end else if (cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                        if (retry_cnt < 4'(MAX_RETRY)) begin
                            retry_next = retry_cnt + 4'd1;
                            state_next = S_RESET;
                        end else begin
                            state_next = S_FAIL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_next = S_WAIT_LOCK;
                    end else if (cnt == CW'(LOCK_STABLE_CYC - 1)) begin
                        state_next = S_RUN;
                        retry_next = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_next = S_RESET;
                        lost_next  = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_next = S_FAIL;
                end
                default: begin
                    state_next = S_RESET;
                end
            endcase
        end
        if (state_next != state) begin
            cnt_clr = 1'b1;
        end
        // RUN and FAIL never consult the counter, so it is parked there
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (state == S_RUN || state == S_FAIL) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    // outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            pll_rst   <= 1'b1;
            sys_ready <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            retry_cnt <= retry_next;
            pll_rst   <= (state_next == S_RESET) || (state_next == S_FAIL);
            sys_ready <= (state_next == S_RUN);
            lock_lost <= lost_next;
            fail      <= (state_next == S_FAIL);
        end
    end

endmodule
